// File: rtl/hwf_sv_streamer.sv
// hwf_sv_streamer: feeds the hwf kernel with (x_test, x_sv) pixel pairs.
// For every support vector it pulses kernel_rst, loads Bi, streams
// NUM_OF_PIXELS pixel pairs (qualified by stall_MEM) and waits for
// kernel_done before moving on to the next support vector.
// Optional feature macro: HWF_ACCUM_EN (adds the decision_sum accumulator).
module hwf_sv_streamer #(
    parameter int XLEN_PIXEL    = 8,
    parameter int NUM_OF_PIXELS = 10,
    parameter int NUM_OF_SV     = 10,
    parameter int SV_AW         = 8,
    parameter int ACC_W         = 24
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             mem_hold,
    output logic [$clog2(NUM_OF_PIXELS)-1:0] test_addr,
    input  logic [XLEN_PIXEL-1:0]            test_rdata,
    output logic [SV_AW-1:0]                 sv_addr,
    input  logic [XLEN_PIXEL-1:0]            sv_rdata,
    output logic [$clog2(NUM_OF_SV)-1:0]     bi_addr,
    input  logic [2*XLEN_PIXEL-1:0]          bi_rdata,
    output logic                             kernel_rst,
    output logic                             stall_MEM,
    output logic [XLEN_PIXEL-1:0]            x_test,
    output logic [XLEN_PIXEL-1:0]            x_sv,
    output logic [2*XLEN_PIXEL-1:0]          Bi,
    input  logic                             kernel_done,
    input  logic [2*XLEN_PIXEL-1:0]          hwf_out,
    output logic [$clog2(NUM_OF_SV)-1:0]     sv_idx,
    output logic                             busy,
    output logic                             done
`ifdef HWF_ACCUM_EN
    ,
    output logic [ACC_W-1:0]                 decision_sum
`endif
);

    localparam int PIX_W = $clog2(NUM_OF_PIXELS);
    localparam int SV_W  = $clog2(NUM_OF_SV);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_OF_PIXELS - 1);
    localparam logic [SV_W-1:0]  LAST_SV  = SV_W'(NUM_OF_SV - 1);

    typedef enum logic [2:0] {
        IDLE,
        KRST,
        FETCH_BI,
        STREAM,
        DRAIN,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PIX_W-1:0] pix;
    logic             issue;

    // Memory addresses follow the pixel/SV counters directly so read data lines up
    // with the registered stall_MEM one cycle later.
    assign test_addr = pix;
    assign sv_addr   = SV_AW'(sv_idx) * SV_AW'(NUM_OF_PIXELS) + SV_AW'(pix);
    assign bi_addr   = sv_idx;
    assign x_test    = test_rdata;
    assign x_sv      = sv_rdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        kernel_rst = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = KRST;
                end
            end
            KRST: begin
                kernel_rst = 1'b1;
                state_nxt  = FETCH_BI;
            end
            FETCH_BI: begin
                state_nxt = STREAM;
            end
            STREAM: begin
                if (!mem_hold) begin
                    issue = 1'b1;
                    if (pix == LAST_PIX) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (kernel_done) begin
                    state_nxt = (sv_idx == LAST_SV) ? FINISH : KRST;
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pixel/SV counters, Bi capture and the registered pixel-valid qualifier.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix       <= '0;
            sv_idx    <= '0;
            Bi        <= '0;
            stall_MEM <= 1'b1;
        end else begin
            stall_MEM <= ~issue;
            if (state == IDLE && start) begin
                sv_idx <= '0;
            end
            if (state == WAIT_DONE && kernel_done && sv_idx != LAST_SV) begin
                sv_idx <= sv_idx + SV_W'(1);
            end
            if (state == KRST) begin
                pix <= '0;
            end else if (issue) begin
                pix <= (pix == LAST_PIX) ? '0 : pix + PIX_W'(1);
            end
            if (state == FETCH_BI) begin
                Bi <= bi_rdata;
            end
        end
    end

`ifdef HWF_ACCUM_EN
    // Sum of kernel results over the pass, restarted whenever a new pass begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            decision_sum <= '0;
        end else if (state == IDLE && start) begin
            decision_sum <= '0;
        end else if (state == WAIT_DONE && kernel_done) begin
            decision_sum <= decision_sum + ACC_W'(hwf_out);
        end
    end
`else
    localparam int unused_acc_w = ACC_W;
    logic unused_hwf_out;
    assign unused_hwf_out = ^hwf_out;
`endif

endmodule

// File: doc/hwf_sv_streamer.md
Name: hwf_sv_streamer

Overview:
- Producer/feeder end of the hwf kernel's pixel interface.
- On a start pulse, it walks every support vector (SV) in turn. For each SV it:
  - resets the kernel,
  - loads the SV's Bi coefficient,
  - streams NUM_OF_PIXELS (x_test, x_sv) pixel pairs, gated by stall_MEM,
  - waits for the kernel's done flag before moving to the next SV.
- Sits between the on-chip test/SV/Bi memories and the kernel in the cascaded SVM datapath.

Parameters:
- XLEN_PIXEL, 8, pixel width; Bi and hwf_out are 2*XLEN_PIXEL wide.
- NUM_OF_PIXELS, 10, pixels per vector.
- NUM_OF_SV, 10, number of support vectors streamed per start.
- SV_AW, 8, SV memory address width; must be ≥ clog2(NUM_OF_SV*NUM_OF_PIXELS).
- ACC_W, 24, accumulator width (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle request to begin a classification pass.
- mem_hold  in  1  memory not ready; freezes address issue.
- test_addr  out  clog2(NUM_OF_PIXELS)  test-vector memory address.
- test_rdata  in  XLEN_PIXEL  test pixel; 1-cycle read latency.
- sv_addr  out  SV_AW  SV memory address, = sv_idx*NUM_OF_PIXELS + pix.
- sv_rdata  in  XLEN_PIXEL  SV pixel; 1-cycle latency.
- bi_addr  out  clog2(NUM_OF_SV)  Bi memory address, = sv_idx.
- bi_rdata  in  2*XLEN_PIXEL  Bi value; 1-cycle latency.
- kernel_rst  out  1  one-cycle reset pulse to the kernel before each SV.
- stall_MEM  out  1  high = x_test/x_sv not valid this cycle.
- x_test  out  XLEN_PIXEL  passthrough of test_rdata.
- x_sv  out  XLEN_PIXEL  passthrough of sv_rdata.
- Bi  out  2*XLEN_PIXEL  registered Bi of the current SV.
- kernel_done  in  1  kernel has finished the current SV.
- hwf_out  in  2*XLEN_PIXEL  kernel result.
- sv_idx  out  clog2(NUM_OF_SV)  current SV index.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at end of pass.

Behaviour:
- Reset values (synchronous, rst high at posedge):
  - state=IDLE; stall_MEM=1; kernel_rst=0; Bi=0; sv_idx=0; busy=0; done=0; all addresses=0; pix=0.
  - rst mid-pass aborts the pass immediately; no done pulse is generated.
- IDLE:
  - busy=0, stall_MEM=1.
  - start -> KRST; sv_idx=0; busy=1.
- KRST:
  - kernel_rst=1 for exactly one cycle.
  - Drive bi_addr=sv_idx; pix=0.
  - -> FETCH_BI.
- FETCH_BI:
  - Bi <= bi_rdata.
  - -> STREAM.
- STREAM: each cycle with mem_hold=0:
  - issue test_addr=pix, sv_addr=sv_idx*NUM_OF_PIXELS+pix;
  - pix increments;
  - issued flag set.
  - When mem_hold=1: no issue, pix holds, issued flag clear.
  - After issuing pix=NUM_OF_PIXELS-1 -> DRAIN.
- stall_MEM:
  - registered; stall_MEM = ~(issue flag of previous cycle).
  - Exactly NUM_OF_PIXELS cycles with stall_MEM=0 per SV, in ascending pixel order.
- DRAIN:
  - the last pixel is presented (stall_MEM=0).
  - -> WAIT_DONE.
- WAIT_DONE:
  - stall_MEM=1.
  - On kernel_done=1:
    - if sv_idx==NUM_OF_SV-1 -> FINISH;
    - else sv_idx++ and -> KRST.
  - kernel_done asserted in any other state is ignored.
- FINISH:
  - done=1 for one cycle; busy drops on the next cycle.
  - -> IDLE.
- start while busy is ignored.
- mem_hold has no effect outside STREAM.
- Bi holds its value from FETCH_BI until the next FETCH_BI.

Optional Feature:
- HWF_ACCUM_EN defined:
  - adds output decision_sum [ACC_W-1:0];
  - cleared on rst and on start accepted in IDLE;
  - in WAIT_DONE, decision_sum += zero-extended hwf_out when kernel_done=1;
  - value is final when done pulses, held until the next start.
  - Accumulation wraps modulo 2^ACC_W.
- Undefined: no port, no accumulator logic.

Test Plan (NUM_OF_PIXELS=4, NUM_OF_SV=2):
- Basic pass: start with mem_hold=0, kernel_done pulsed 3 cycles after entering WAIT_DONE -> kernel_rst pulses twice; sv_addr sequences 0,1,2,3 then 4,5,6,7; stall_MEM low for 4 consecutive cycles per SV; done pulses once; busy low afterwards.
- Bi load: bi_rdata = 0x0120 for SV0 and 0x0345 for SV1 -> Bi equals 0x0120 throughout SV0 streaming and 0x0345 throughout SV1 streaming.
- Hold: mem_hold high on the 2nd STREAM cycle for 3 cycles -> stall_MEM high for 3 cycles; still exactly 4 valid pixels with no duplication or skipping (x_sv sequence 0,1,2,3 by address).
- start while busy plus early kernel_done: start reasserted during STREAM, kernel_done pulsed during STREAM -> both ignored; sequence identical to the basic pass.
- Reset mid-pass: rst in WAIT_DONE of SV0 -> next cycle stall_MEM=1, busy=0, sv_idx=0, no done pulse; a new start then runs a full pass.
- HWF_ACCUM_EN: hwf_out=0x0100 then 0x0050 -> decision_sum=0x000150 at done; after a new start it is 0.
